// File: rtl/gray_hgrad.sv
// Horizontal-gradient stage for a gray pixel stream: |x - x_prev| per row,
// a threshold edge flag and row/frame position markers, one output register.
module gray_hgrad #(
    parameter int unsigned width_p      = 8,
    parameter int unsigned line_width_p = 640,
    parameter int unsigned height_p     = 480
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic [width_p-1:0] gray_i,
    output logic               ready_o,
    input  logic [width_p-1:0] threshold_i,
    output logic               valid_o,
    output logic [width_p-1:0] grad_o,
    output logic               edge_o,
    output logic               eol_o,
    output logic               sof_o,
    output logic               eof_o,
    input  logic               ready_i
);

    localparam int unsigned COL_W = (line_width_p > 1) ? $clog2(line_width_p) : 1;
    localparam int unsigned ROW_W = (height_p > 1) ? $clog2(height_p) : 1;
    localparam int unsigned DIF_W = width_p + 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(line_width_p - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(height_p - 1);

    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic [width_p-1:0] r_prev;
    logic               r_valid;
    logic [width_p-1:0] r_grad;
    logic               r_edge;
    logic               r_eol;
    logic               r_sof;
    logic               r_eof;

    logic               w_accept;
    logic               w_col0;
    logic               w_eol;
    logic               w_sof;
    logic               w_eof;
    logic [DIF_W-1:0]   w_gray_x;
    logic [DIF_W-1:0]   w_prev_x;
    logic [DIF_W-1:0]   w_abs;
    logic [width_p-1:0] w_grad;
    logic               w_edge;

    // Skid-free output stage: accept whenever the output slot is free or draining
    assign ready_o  = ready_i | ~r_valid;
    assign w_accept = valid_i & ready_o;

    // Position flags and absolute difference for the pixel being accepted
    always_comb begin
        w_col0   = (r_col == '0);
        w_eol    = (r_col == COL_LAST);
        w_sof    = w_col0 && (r_row == '0);
        w_eof    = w_eol && (r_row == ROW_LAST);
        w_gray_x = DIF_W'(gray_i);
        w_prev_x = DIF_W'(r_prev);
        w_abs    = (w_gray_x >= w_prev_x) ? (w_gray_x - w_prev_x) : (w_prev_x - w_gray_x);
        w_grad   = w_col0 ? '0 : width_p'(w_abs);
        w_edge   = (w_grad > threshold_i);
    end

    // Column/row position and previous-pixel tracking, advanced only on accept
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_col  <= '0;
            r_row  <= '0;
            r_prev <= '0;
        end else if (w_accept) begin
            r_prev <= gray_i;
            if (w_eol) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : (r_row + ROW_W'(1));
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Output register: load on accept, clear valid on drain, hold on stall
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid <= 1'b0;
            r_grad  <= '0;
            r_edge  <= 1'b0;
            r_eol   <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_grad  <= w_grad;
            r_edge  <= w_edge;
            r_eol   <= w_eol;
            r_sof   <= w_sof;
            r_eof   <= w_eof;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign grad_o  = r_grad;
    assign edge_o  = r_edge;
    assign eol_o   = r_eol;
    assign sof_o   = r_sof;
    assign eof_o   = r_eof;

endmodule

// File: tb/tb_gray_hgrad.sv
// Directed self-checking bench for gray_hgrad (4x2 frame, 8-bit pixels).
module tb_gray_hgrad;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       valid_i;
    logic [7:0] gray_i;
    logic       ready_o;
    logic [7:0] threshold_i;
    logic       valid_o;
    logic [7:0] grad_o;
    logic       edge_o;
    logic       eol_o;
    logic       sof_o;
    logic       eof_o;
    logic       ready_i;

    int errors = 0;
    int checks = 0;

    gray_hgrad #(.width_p(8), .line_width_p(4), .height_p(2)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .valid_i     (valid_i),
        .gray_i      (gray_i),
        .ready_o     (ready_o),
        .threshold_i (threshold_i),
        .valid_o     (valid_o),
        .grad_o      (grad_o),
        .edge_o      (edge_o),
        .eol_o       (eol_o),
        .sof_o       (sof_o),
        .eof_o       (eof_o),
        .ready_i     (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        reset_i = 1'b0;
    endtask

    // Present one pixel and let it be accepted (ready_i assumed high)
    task automatic send(input logic [7:0] pix);
        valid_i = 1'b1;
        gray_i  = pix;
        tick();
    endtask

    task automatic test_reset();
        reset_i     = 1'b1;
        valid_i     = 1'b1;
        gray_i      = 8'd77;
        threshold_i = 8'd0;
        ready_i     = 1'b0;
        tick();
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if ({grad_o, edge_o, eol_o, sof_o, eof_o} !== 12'h000) begin
            errors++; $display("FAIL reset_data got grad=%0d e=%b eol=%b sof=%b eof=%b exp all 0", grad_o, edge_o, eol_o, sof_o, eof_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        ready_i = 1'b1;
        reset_i = 1'b0;
        send(8'd33);
        checks++; if ({valid_o, sof_o, grad_o} !== {1'b1, 1'b1, 8'd0}) begin
            errors++; $display("FAIL first_after_reset got v=%b sof=%b grad=%0d exp v=1 sof=1 grad=0", valid_o, sof_o, grad_o); end
        valid_i = 1'b0;
    endtask

    task automatic test_row_gradient();
        logic [7:0] pix [4];
        logic [7:0] eg  [4];
        logic [3:0] ee;
        logic [3:0] el;
        logic [3:0] es;
        pix[0] = 8'd100; pix[1] = 8'd120; pix[2] = 8'd115; pix[3] = 8'd0;
        eg[0]  = 8'd0;   eg[1]  = 8'd20;  eg[2]  = 8'd5;   eg[3]  = 8'd115;
        ee = 4'b1010; el = 4'b1000; es = 4'b0001;
        do_reset();
        threshold_i = 8'd10;
        for (int i = 0; i < 4; i++) begin
            send(pix[i]);
            checks++;
            if ({valid_o, grad_o, edge_o, eol_o, sof_o, eof_o} !== {1'b1, eg[i], ee[i], el[i], es[i], 1'b0}) begin
                errors++;
                $display("FAIL row_beat%0d got v=%b grad=%0d e=%b eol=%b sof=%b eof=%b exp v=1 grad=%0d e=%b eol=%b sof=%b eof=0",
                         i, valid_o, grad_o, edge_o, eol_o, sof_o, eof_o, eg[i], ee[i], el[i], es[i]);
            end
        end
        valid_i = 1'b0;
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL row_drain got v=%b exp=0", valid_o); end
    endtask

    task automatic test_frame_wrap();
        do_reset();
        threshold_i = 8'd10;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] eg;
            logic       eol_e, sof_e, eof_e;
            eg    = ((i % 4) == 0) ? 8'd0 : 8'd10;
            eol_e = ((i % 4) == 3);
            sof_e = ((i % 8) == 0);
            eof_e = ((i % 8) == 7);
            send(((i % 2) == 0) ? 8'd50 : 8'd60);
            checks++;
            if ({grad_o, edge_o, eol_o, sof_o, eof_o} !== {eg, 1'b0, eol_e, sof_e, eof_e}) begin
                errors++;
                $display("FAIL wrap_beat%0d got grad=%0d e=%b eol=%b sof=%b eof=%b exp grad=%0d e=0 eol=%b sof=%b eof=%b",
                         i + 1, grad_o, edge_o, eol_o, sof_o, eof_o, eg, eol_e, sof_e, eof_e);
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        threshold_i = 8'd100;
        send(8'd10);
        ready_i = 1'b0;
        valid_i = 1'b1;
        gray_i  = 8'd200;
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", ready_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({ready_o, valid_o, grad_o, edge_o, eol_o, sof_o, eof_o} !== {1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold%0d got rdy=%b v=%b grad=%0d e=%b eol=%b sof=%b eof=%b exp rdy=0 v=1 grad=0 e=0 eol=0 sof=1 eof=0",
                         i, ready_o, valid_o, grad_o, edge_o, eol_o, sof_o, eof_o);
            end
        end
        ready_i = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", ready_o); end
        tick();
        checks++;
        if ({valid_o, grad_o, edge_o, sof_o, eol_o} !== {1'b1, 8'd190, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL release_beat got v=%b grad=%0d e=%b sof=%b eol=%b exp v=1 grad=190 e=1 sof=0 eol=0",
                     valid_o, grad_o, edge_o, sof_o, eol_o);
        end
        send(8'd30);
        checks++; if ({grad_o, eol_o} !== {8'd170, 1'b0}) begin errors++; $display("FAIL post_stall_col2 got grad=%0d eol=%b exp grad=170 eol=0", grad_o, eol_o); end
        send(8'd30);
        checks++; if ({grad_o, eol_o, edge_o} !== {8'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL post_stall_col3 got grad=%0d eol=%b e=%b exp grad=0 eol=1 e=0", grad_o, eol_o, edge_o); end
        valid_i = 1'b0;
    endtask

    task automatic test_extremes();
        do_reset();
        threshold_i = 8'd255;
        send(8'd255);
        send(8'd0);
        checks++; if ({grad_o, edge_o} !== {8'd255, 1'b0}) begin errors++; $display("FAIL extreme_thr255 got grad=%0d e=%b exp grad=255 e=0", grad_o, edge_o); end
        threshold_i = 8'd254;
        send(8'd255);
        checks++; if ({grad_o, edge_o} !== {8'd255, 1'b1}) begin errors++; $display("FAIL extreme_thr254 got grad=%0d e=%b exp grad=255 e=1", grad_o, edge_o); end
        threshold_i = 8'd0;
        send(8'd255);
        checks++; if ({grad_o, edge_o, eol_o} !== {8'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL equal_pixels got grad=%0d e=%b eol=%b exp grad=0 e=0 eol=1", grad_o, edge_o, eol_o); end
        valid_i = 1'b0;
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL extreme_drain got v=%b exp=0", valid_o); end
    endtask

    task automatic test_reset_mid_row();
        do_reset();
        threshold_i = 8'd0;
        send(8'd1);
        send(8'd2);
        reset_i = 1'b1;
        gray_i  = 8'd99;
        tick();
        reset_i = 1'b0;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrow_reset_valid got=%b exp=0", valid_o); end
        for (int i = 0; i < 4; i++) begin
            send(8'd9 + 8'(i));
            checks++;
            if ({grad_o, sof_o, eol_o} !== {((i == 0) ? 8'd0 : 8'd1), (i == 0), (i == 3)}) begin
                errors++;
                $display("FAIL midrow_beat%0d got grad=%0d sof=%b eol=%b exp grad=%0d sof=%b eol=%b",
                         i, grad_o, sof_o, eol_o, (i == 0) ? 0 : 1, (i == 0), (i == 3));
            end
        end
        valid_i = 1'b0;
    endtask

    initial begin
        reset_i     = 1'b1;
        valid_i     = 1'b0;
        gray_i      = 8'd0;
        threshold_i = 8'd0;
        ready_i     = 1'b1;
        test_reset();
        test_row_gradient();
        test_frame_wrap();
        test_backpressure();
        test_extremes();
        test_reset_mid_row();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
